nfa_stream_driver: RTL
======================

NFA_STREAM_DRIVER -- requirements
Module: nfa_stream_driver

Interface
REQ-001 Parameter NUM_ENG, default 8, number of engine instances driven in parallel.
REQ-002 Parameter ENG_LAT, default 2, cycles from a char accepted with en high to its effect on engine out.
REQ-003 Parameter CNT_W, default 16, width of byte counters.
REQ-004 Parameter FLUSH_CHAR, default 8'h00, char presented during drain.
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 in_valid  input  1  input byte available.
REQ-008 in_ready  output  1  block accepts byte this cycle.
REQ-009 in_data  input  8  packet byte.
REQ-010 in_last  input  1  byte is final byte of packet.
REQ-011 eng_char  output  8  char bus to all engines.
REQ-012 eng_sod  output  1  start-of-data; clears all engine state.
REQ-013 eng_en  output  1  engine clock enable.
REQ-014 eng_match  input  NUM_ENG  engine out bits, one per engine.
REQ-015 res_valid  output  1  packet result available.
REQ-016 res_ready  input  1  consumer takes result.
REQ-017 res_match  output  NUM_ENG  engines that matched anywhere in packet.
REQ-018 res_len  output  CNT_W  packet byte count.
REQ-019 res_first  output  CNT_W  index (0-based) of byte causing first match; all-ones if none.

Function
REQ-020 FSM states SHALL be IDLE, SOD, STREAM, DRAIN, REPORT.
REQ-021 IDLE: in_ready=0, eng_sod=0, eng_en=0; on in_valid go to SOD.
REQ-022 SOD: eng_sod=1, eng_en=1 for exactly one cycle; clear match accumulator, byte counter and res_first; go to STREAM.
REQ-023 STREAM: in_ready=1; eng_char registered from in_data and eng_en=1 only in the cycle after a handshake; eng_en=0 in bubble cycles (engine state frozen).
REQ-024 Byte counter increments per handshake, saturating at all-ones.
REQ-025 Handshake with in_last=1 SHALL move to DRAIN after that byte is issued; in_ready=0 from the cycle after.
REQ-026 DRAIN: eng_en=1, eng_char=FLUSH_CHAR for exactly ENG_LAT cycles, then REPORT.
REQ-027 Each cycle in STREAM/DRAIN, accumulator ORs eng_match.
REQ-028 res_first SHALL be captured once, on first cycle accumulator goes nonzero, as (count of bytes issued with eng_en) - ENG_LAT; a match seen during drain uses the same rule.
REQ-029 REPORT: res_valid=1 with stable res_*; on res_ready go to IDLE (or directly SOD if in_valid, zero bubble).
REQ-030 res_valid SHALL NOT drop without res_ready; in_ready=0 throughout REPORT.
REQ-031 Single-byte packet (in_last on first byte) SHALL yield res_len=1.
REQ-032 Bit-wise saturation: res_len stays all-ones beyond 2^CNT_W-1 bytes; res_first unaffected.

Reset
REQ-033 rst SHALL force IDLE asynchronously; outputs: in_ready=0, eng_sod=0, eng_en=0, eng_char=0, res_valid=0, res_match=0, res_len=0, res_first=all-ones.
REQ-034 rst mid-packet SHALL discard the packet; no result emitted.

Structure
REQ-035 FSM state enum, default parameter values and the "no match" all-ones constant SHALL live in shared package nfa_pkg.
REQ-036 One sub-module nfa_match_accum (OR accumulator plus first-match capture) SHALL be instantiated; remainder flat.

Verification
REQ-037 Bytes "a5" (in_last on '5') into one digit-class engine, ENG_LAT=2 -> res_match=1, res_len=2, res_first=1.
REQ-038 Packet "xyz", no engine fires -> res_match=0, res_len=3, res_first=16'hFFFF.
REQ-039 in_valid toggling every other cycle over 4 bytes -> eng_en high exactly 4 cycles in STREAM, result identical to gapless case.
REQ-040 res_ready held low 10 cycles -> res_valid and res_* stable, in_ready=0, then back-to-back packet starts with SOD next cycle.
REQ-041 rst asserted on byte 3 of 6 -> outputs at reset values same cycle, no res_valid, next packet reports res_len counting from 0.
REQ-042 Single-byte packet '7' -> one SOD cycle, one char cycle, 2 drain cycles, res_len=1, res_first=0.

Source files
------------

// File: rtl/nfa_pkg.sv
// Shared definitions for the NFA stream driver: FSM encoding, parameter
// defaults and the all-ones "no match" marker.
package nfa_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SOD,
    ST_STREAM,
    ST_DRAIN,
    ST_REPORT
  } state_e;

  localparam int unsigned NUM_ENG_DEF    = 8;
  localparam int unsigned ENG_LAT_DEF    = 2;
  localparam int unsigned CNT_W_DEF      = 16;
  localparam logic [7:0]  FLUSH_CHAR_DEF = 8'h00;

  // Wide enough for any counter width; users slice to CNT_W.
  localparam logic [63:0] NO_MATCH = '1;

endpackage

// File: rtl/nfa_match_accum.sv
// Sticky OR of engine match bits over a packet, plus capture of the byte
// index that produced the first match.
module nfa_match_accum
  import nfa_pkg::*;
#(
  parameter int unsigned NUM_ENG = NUM_ENG_DEF,
  parameter int unsigned ENG_LAT = ENG_LAT_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr_i,
  input  logic               active_i,
  input  logic [NUM_ENG-1:0] match_i,
  input  logic [CNT_W-1:0]   issued_i,
  output logic [NUM_ENG-1:0] acc_o,
  output logic [CNT_W-1:0]   first_o
);

  logic [NUM_ENG-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]   first_q, first_d;

  always_comb begin
    acc_d   = acc_q;
    first_d = first_q;
    if (clr_i) begin
      acc_d   = '0;
      first_d = NO_MATCH[CNT_W-1:0];
    end else if (active_i) begin
      acc_d = acc_q | match_i;
      // issued_i counts enabled chars before this cycle; the match seen now
      // belongs to the char ENG_LAT enabled cycles back.
      if ((acc_q == '0) && (match_i != '0)) begin
        first_d = issued_i - CNT_W'(ENG_LAT);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q   <= '0;
      first_q <= NO_MATCH[CNT_W-1:0];
    end else begin
      acc_q   <= acc_d;
      first_q <= first_d;
    end
  end

  assign acc_o   = acc_q;
  assign first_o = first_q;

endmodule

// File: rtl/nfa_stream_driver.sv
// Feeds a packet byte stream to a bank of NFA engines in lock-step, drains
// the engine pipeline and reports per-packet match summary.
module nfa_stream_driver
  import nfa_pkg::*;
#(
  parameter int unsigned NUM_ENG    = NUM_ENG_DEF,
  parameter int unsigned ENG_LAT    = ENG_LAT_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF,
  parameter logic [7:0]  FLUSH_CHAR = FLUSH_CHAR_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [7:0]         in_data,
  input  logic               in_last,
  output logic [7:0]         eng_char,
  output logic               eng_sod,
  output logic               eng_en,
  input  logic [NUM_ENG-1:0] eng_match,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [NUM_ENG-1:0] res_match,
  output logic [CNT_W-1:0]   res_len,
  output logic [CNT_W-1:0]   res_first
);

  localparam int unsigned DRW = (ENG_LAT > 1) ? $clog2(ENG_LAT) : 1;

  state_e           state_q, state_d;
  logic [7:0]       eng_char_q, eng_char_d;
  logic             eng_en_q, eng_en_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] iss_q, iss_d;
  logic [DRW-1:0]   drain_q, drain_d;
  logic             hs;
  logic             active;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign in_ready  = (state_q == ST_STREAM) && !last_q;
  assign hs        = in_valid && in_ready;
  assign active    = (state_q == ST_STREAM) || (state_q == ST_DRAIN);
  assign eng_sod   = (state_q == ST_SOD);
  assign eng_en    = eng_en_q;
  assign eng_char  = eng_char_q;
  assign res_valid = (state_q == ST_REPORT);
  assign res_len   = len_q;

  always_comb begin
    state_d    = state_q;
    eng_char_d = eng_char_q;
    eng_en_d   = 1'b0;
    last_d     = last_q;
    len_d      = len_q;
    iss_d      = iss_q;
    drain_d    = drain_q;

    if (active && eng_en_q) begin
      iss_d = sat_inc(iss_q);
    end

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d    = ST_SOD;
          eng_en_d   = 1'b1;
          eng_char_d = FLUSH_CHAR;
        end
      end
      ST_SOD: begin
        state_d = ST_STREAM;
        len_d   = '0;
        iss_d   = '0;
        last_d  = 1'b0;
      end
      ST_STREAM: begin
        // The last byte is on the engine bus while last_q is set; flushing
        // starts on the following cycle.
        if (last_q) begin
          state_d    = ST_DRAIN;
          eng_en_d   = 1'b1;
          eng_char_d = FLUSH_CHAR;
          drain_d    = '0;
        end else if (hs) begin
          eng_en_d   = 1'b1;
          eng_char_d = in_data;
          len_d      = sat_inc(len_q);
          last_d     = in_last;
        end
      end
      ST_DRAIN: begin
        if (drain_q == DRW'(ENG_LAT - 1)) begin
          state_d = ST_REPORT;
        end else begin
          drain_d    = drain_q + DRW'(1);
          eng_en_d   = 1'b1;
          eng_char_d = FLUSH_CHAR;
        end
      end
      ST_REPORT: begin
        if (res_ready) begin
          if (in_valid) begin
            state_d    = ST_SOD;
            eng_en_d   = 1'b1;
            eng_char_d = FLUSH_CHAR;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      eng_char_q <= '0;
      eng_en_q   <= 1'b0;
      last_q     <= 1'b0;
      len_q      <= '0;
      iss_q      <= '0;
      drain_q    <= '0;
    end else begin
      state_q    <= state_d;
      eng_char_q <= eng_char_d;
      eng_en_q   <= eng_en_d;
      last_q     <= last_d;
      len_q      <= len_d;
      iss_q      <= iss_d;
      drain_q    <= drain_d;
    end
  end

  nfa_match_accum #(
    .NUM_ENG (NUM_ENG),
    .ENG_LAT (ENG_LAT),
    .CNT_W   (CNT_W)
  ) u_accum (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (eng_sod),
    .active_i (active),
    .match_i  (eng_match),
    .issued_i (iss_q),
    .acc_o    (res_match),
    .first_o  (res_first)
  );

endmodule
